// File: rtl/apb_timer_sched_if.sv
// APB master/slave bundle used by apb_timer_sched to program its dedicated timer.
interface apb_timer_sched_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_timer_sched.sv
// Round-robin scheduler sharing one apb_timer among NUM_REQ one-shot timeout requesters.
// Grants a requester, writes PRESCALER then CMP, waits for the compare irq (or overflow /
// cancel), disarms the timer with CMP=0 and pulses done_o with a status code.
module apb_timer_sched #(
    parameter int unsigned               NUM_REQ        = 4,
    parameter int unsigned               APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = '0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*32-1:0]      req_cmp_i,
    input  logic [NUM_REQ*32-1:0]      req_presc_i,
    input  logic [NUM_REQ-1:0]         cancel_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [1:0]                 status_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] active_id_o,
    input  logic [1:0]                 timer_irq_i,
    apb_timer_sched_if.master          apb
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    localparam logic [APB_ADDR_WIDTH-1:0] AddrPresc = TIMER_BASE + APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] AddrCmp   = TIMER_BASE + APB_ADDR_WIDTH'(8);

    localparam logic [1:0] StsOk     = 2'b00;
    localparam logic [1:0] StsOvf    = 2'b01;
    localparam logic [1:0] StsBusErr = 2'b10;
    localparam logic [1:0] StsCancel = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StPrescSetup,
        StPrescAccess,
        StCmpSetup,
        StCmpAccess,
        StWait,
        StDisSetup,
        StDisAccess,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] id_q, id_d;
    logic [31:0]    cmp_q, cmp_d;
    logic [31:0]    presc_q, presc_d;
    logic [1:0]     status_q, status_d;

    logic           found;
    logic [IdW-1:0] sel;
    logic [IdW-1:0] idx;
    logic [31:0]    cmp_sel;
    logic [31:0]    presc_sel;

    // Read data is never needed: the timer is only ever written.
    logic unused_prdata;
    assign unused_prdata = ^apb.PRDATA;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IdW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign cmp_sel   = req_cmp_i[{sel, 5'd0} +: 32];
    assign presc_sel = req_presc_i[{sel, 5'd0} +: 32];

    // Next-state logic: arbitration, APB sequencing and completion status.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cmp_d    = cmp_q;
        presc_d  = presc_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    id_d    = sel;
                    cmp_d   = cmp_sel;
                    presc_d = presc_sel;
                    ptr_d   = (sel == IdW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    // CMP=0 would never raise a compare irq, so finish without touching the bus.
                    if (cmp_sel == '0) begin
                        status_d = StsCancel;
                        state_d  = StDone;
                    end else begin
                        status_d = StsOk;
                        state_d  = StPrescSetup;
                    end
                end
            end
            StPrescSetup: state_d = StPrescAccess;
            StPrescAccess: begin
                if (apb.PREADY) begin
                    if (apb.PSLVERR) begin
                        status_d = StsBusErr;
                        state_d  = StDisSetup;
                    end else begin
                        state_d = StCmpSetup;
                    end
                end
            end
            StCmpSetup: state_d = StCmpAccess;
            StCmpAccess: begin
                if (apb.PREADY) begin
                    if (apb.PSLVERR) begin
                        status_d = StsBusErr;
                        state_d  = StDisSetup;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (timer_irq_i[1]) begin
                    status_d = StsOk;
                    state_d  = StDisSetup;
                end else if (timer_irq_i[0]) begin
                    status_d = StsOvf;
                    state_d  = StDisSetup;
                end else if (cancel_i[id_q]) begin
                    status_d = StsCancel;
                    state_d  = StDisSetup;
                end
            end
            StDisSetup: state_d = StDisAccess;
            StDisAccess: begin
                if (apb.PREADY) begin
                    if (apb.PSLVERR) begin
                        status_d = StsBusErr;
                    end
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched-operand registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            cmp_q    <= '0;
            presc_q  <= '0;
            status_q <= StsOk;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cmp_q    <= cmp_d;
            presc_q  <= presc_d;
            status_q <= status_d;
        end
    end

    // Outputs: APB master phases, grant/done pulses and status.
    always_comb begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        gnt_o       = '0;
        done_o      = '0;
        status_o    = 2'b00;
        unique case (state_q)
            StPrescSetup, StPrescAccess: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (state_q == StPrescAccess);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = AddrPresc;
                apb.PWDATA  = presc_q;
            end
            StCmpSetup, StCmpAccess: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (state_q == StCmpAccess);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = AddrCmp;
                apb.PWDATA  = cmp_q;
            end
            StDisSetup, StDisAccess: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = (state_q == StDisAccess);
                apb.PWRITE  = 1'b1;
                apb.PADDR   = AddrCmp;
            end
            StDone: begin
                done_o[id_q] = 1'b1;
                status_o     = status_q;
            end
            default: ;
        endcase
        // The grant is combinational in IDLE; keep it quiet while reset is held.
        if (state_q == StIdle && found && HRESETn) begin
            gnt_o[sel] = 1'b1;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign active_id_o = id_q;

endmodule
